// File: rtl/traffic_light_ctrl_if.sv
// Timer handshake between the traffic-light controller (master) and its interval timer (slave).
// st restarts the timer; ts/tl are sticky interval-done flags that stay high until the next st.
interface traffic_light_ctrl_if;
  logic st;
  logic ts;
  logic tl;

  modport master (output st, input ts, input tl);
  modport slave  (input st, output ts, output tl);
endinterface

// File: rtl/traffic_light_ctrl.sv
// Highway / farm-road traffic-light sequencer with latched pedestrian request and night flashing mode.
// Lights are Moore-decoded from the registered state; st pulses in the first cycle of each new state.
module traffic_light_ctrl #(
  parameter int FLASH_DIV = 1
) (
  input  logic                        clk1,
  input  logic                        rst_n,
  input  logic                        car,
  input  logic                        ped_req,
  input  logic                        night,
  traffic_light_ctrl_if.master        tmr,
  output logic [2:0]                  hl,
  output logic [2:0]                  fl,
  output logic                        walk,
  output logic                        ped_pend
);

  localparam int CW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;

  typedef enum logic [2:0] {
    S_HG    = 3'd0,
    S_HY    = 3'd1,
    S_FG    = 3'd2,
    S_FY    = 3'd3,
    S_FLASH = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic          st_q, st_d;
  logic          ped_pend_q, ped_pend_d;
  logic          walk_q, walk_d;
  logic          blink_q, blink_d;
  logic [CW-1:0] blink_cnt_q, blink_cnt_d;
  logic          ts_eff, tl_eff;
  logic          hy_to_fg;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_HG;
      st_q        <= 1'b1;
      ped_pend_q  <= 1'b0;
      walk_q      <= 1'b0;
      blink_q     <= 1'b0;
      blink_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      st_q        <= st_d;
      ped_pend_q  <= ped_pend_d;
      walk_q      <= walk_d;
      blink_q     <= blink_d;
      blink_cnt_q <= blink_cnt_d;
    end
  end

  // Flags seen while st is high belong to the previous interval and must not advance the state.
  always_comb begin
    ts_eff  = tmr.ts & ~st_q;
    tl_eff  = tmr.tl & ~st_q;
    state_d = state_q;
    case (state_q)
      S_HG:    if ((tl_eff && (car || ped_pend_q)) || (ts_eff && night)) state_d = S_HY;
      S_HY:    if (ts_eff) state_d = night ? S_FLASH : S_FG;
      S_FG:    if (tl_eff || (ts_eff && !car && !walk_q)) state_d = S_FY;
      S_FY:    if (ts_eff) state_d = S_HG;
      S_FLASH: if (!night) state_d = S_HG;
      default: state_d = S_HG;
    endcase
    st_d = (state_d != state_q);
  end

  always_comb begin
    hy_to_fg   = (state_q == S_HY) && (state_d == S_FG);
    ped_pend_d = ped_pend_q;
    if (ped_req && !((state_q == S_FG) && walk_q)) ped_pend_d = 1'b1;
    if (hy_to_fg) ped_pend_d = 1'b0;

    walk_d = walk_q;
    if (hy_to_fg) begin
      walk_d = ped_pend_q | ped_req;
    end else if (state_d != S_FG) begin
      walk_d = 1'b0;
    end
  end

  // Blink starts lit on FLASH entry and toggles every FLASH_DIV cycles while in FLASH.
  always_comb begin
    blink_d     = 1'b0;
    blink_cnt_d = '0;
    if (state_d == S_FLASH) begin
      if (state_q != S_FLASH) begin
        blink_d     = 1'b1;
        blink_cnt_d = '0;
      end else if (blink_cnt_q == CW'(FLASH_DIV - 1)) begin
        blink_d     = ~blink_q;
        blink_cnt_d = '0;
      end else begin
        blink_d     = blink_q;
        blink_cnt_d = blink_cnt_q + CW'(1);
      end
    end
  end

  always_comb begin
    hl = 3'b100;
    fl = 3'b100;
    case (state_q)
      S_HG:    begin hl = 3'b001; fl = 3'b100; end
      S_HY:    begin hl = 3'b010; fl = 3'b100; end
      S_FG:    begin hl = 3'b100; fl = 3'b001; end
      S_FY:    begin hl = 3'b100; fl = 3'b010; end
      S_FLASH: begin hl = {1'b0, blink_q, 1'b0}; fl = {1'b0, blink_q, 1'b0}; end
      default: begin hl = 3'b100; fl = 3'b100; end
    endcase
  end

  assign tmr.st   = st_q;
  assign walk     = walk_q;
  assign ped_pend = ped_pend_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl with a sticky-flag interval timer (TS=5, TL=15).
// Observed vector is {st, walk, ped_pend, hl, fl}, sampled 1 time unit after each rising edge.
module tb_traffic_light_ctrl;

  localparam int TS = 5;
  localparam int TL = 15;

  localparam logic [5:0] HG_L   = 6'b001_100;
  localparam logic [5:0] HY_L   = 6'b010_100;
  localparam logic [5:0] FG_L   = 6'b100_001;
  localparam logic [5:0] FY_L   = 6'b100_010;
  localparam logic [5:0] FL_ON  = 6'b010_010;
  localparam logic [5:0] FL_OFF = 6'b000_000;

  logic       clk1 = 1'b0;
  logic       rst_n = 1'b0;
  logic       car = 1'b0;
  logic       ped_req = 1'b0;
  logic       night = 1'b0;
  logic [2:0] hl, fl;
  logic       walk, ped_pend;
  int         tmr_cnt;
  int         cyc;
  int         check_count = 0;
  int         error_count = 0;

  traffic_light_ctrl_if tmr_if ();

  traffic_light_ctrl #(.FLASH_DIV(1)) dut (
    .clk1     (clk1),
    .rst_n    (rst_n),
    .car      (car),
    .ped_req  (ped_req),
    .night    (night),
    .tmr      (tmr_if),
    .hl       (hl),
    .fl       (fl),
    .walk     (walk),
    .ped_pend (ped_pend)
  );

  always #5 clk1 = ~clk1;

  // Timer model: cleared while st is high, counts up and saturates; flags stay high until restart.
  always @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) tmr_cnt <= 0;
    else if (tmr_if.st) tmr_cnt <= 0;
    else if (tmr_cnt < TL) tmr_cnt <= tmr_cnt + 1;
  end
  assign tmr_if.ts = (tmr_cnt >= TS);
  assign tmr_if.tl = (tmr_cnt >= TL);

  task automatic checkOutput(input string tag, input logic [8:0] observed, input logic [8:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %b, expected %b (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  function automatic logic [8:0] obs();
    return {tmr_if.st, walk, ped_pend, hl, fl};
  endfunction

  function automatic logic [8:0] exp_v(input logic s, input logic w, input logic p, input logic [5:0] lights);
    return {s, w, p, lights};
  endfunction

  task automatic applyReset(input logic car_v, input logic night_v);
    @(negedge clk1);
    rst_n   = 1'b0;
    car     = car_v;
    night   = night_v;
    ped_req = 1'b0;
    @(negedge clk1);
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
    cyc++;
  endtask

  task automatic tickTo(input int n);
    while (cyc < n) tick();
  endtask

  // Pedestrian pulse in HG, car absent: HY at edge 17, FG with walk at edge 24.
  task automatic applyStimulus();
    applyReset(1'b0, 1'b0);
    tickTo(2);
    ped_req = 1'b1;
    tick();
    ped_req = 1'b0;
    checkOutput("ped_latched", obs(), exp_v(1'b0, 1'b0, 1'b1, HG_L));
    tickTo(17);
    checkOutput("ped_hy_entry", obs(), exp_v(1'b1, 1'b0, 1'b1, HY_L));
    tickTo(24);
    checkOutput("ped_fg_walk", obs(), exp_v(1'b1, 1'b1, 1'b0, FG_L));
    tickTo(30);
    checkOutput("ped_fg_hold_past_ts", obs(), exp_v(1'b0, 1'b1, 1'b0, FG_L));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    cyc = 0;

    // Idle: no car, no pedestrian, no night -> HG forever, st only right after reset
    applyReset(1'b0, 1'b0);
    checkOutput("reset_values", obs(), exp_v(1'b1, 1'b0, 1'b0, HG_L));
    for (int i = 0; i < 40; i++) begin
      tick();
      checkOutput("idle_hg", obs(), exp_v(1'b0, 1'b0, 1'b0, HG_L));
    end

    // Car on farm road: HG -> HY -> FG -> FY -> HG
    applyReset(1'b1, 1'b0);
    tickTo(16);
    checkOutput("car_hg_before_tl", obs(), exp_v(1'b0, 1'b0, 1'b0, HG_L));
    tick();
    checkOutput("car_hy_entry", obs(), exp_v(1'b1, 1'b0, 1'b0, HY_L));
    tick();
    checkOutput("car_hy_stale_flags", obs(), exp_v(1'b0, 1'b0, 1'b0, HY_L));
    tickTo(23);
    checkOutput("car_hy_last", obs(), exp_v(1'b0, 1'b0, 1'b0, HY_L));
    tick();
    checkOutput("car_fg_entry", obs(), exp_v(1'b1, 1'b0, 1'b0, FG_L));
    tickTo(27);
    car = 1'b0;
    tickTo(30);
    checkOutput("car_fg_last", obs(), exp_v(1'b0, 1'b0, 1'b0, FG_L));
    tick();
    checkOutput("car_fy_entry", obs(), exp_v(1'b1, 1'b0, 1'b0, FY_L));
    tickTo(37);
    checkOutput("car_fy_last", obs(), exp_v(1'b0, 1'b0, 1'b0, FY_L));
    tick();
    checkOutput("car_hg_return", obs(), exp_v(1'b1, 1'b0, 1'b0, HG_L));
    tick();
    checkOutput("car_hg_st_drop", obs(), exp_v(1'b0, 1'b0, 1'b0, HG_L));

    // Pedestrian request: FG held to tl with walk lit, walk off in FY
    applyStimulus();
    tickTo(40);
    checkOutput("ped_fg_last", obs(), exp_v(1'b0, 1'b1, 1'b0, FG_L));
    tick();
    checkOutput("ped_fy_walk_off", obs(), exp_v(1'b1, 1'b0, 1'b0, FY_L));

    // Night mode: HY at ts, FLASH at next ts, blink each cycle, back to HG when night drops
    applyReset(1'b0, 1'b1);
    tickTo(7);
    checkOutput("night_hy_entry", obs(), exp_v(1'b1, 1'b0, 1'b0, HY_L));
    tick();
    checkOutput("night_hy_stale_ts", obs(), exp_v(1'b0, 1'b0, 1'b0, HY_L));
    tickTo(14);
    checkOutput("flash_entry_on", obs(), exp_v(1'b1, 1'b0, 1'b0, FL_ON));
    tick();
    checkOutput("flash_off_1", obs(), exp_v(1'b0, 1'b0, 1'b0, FL_OFF));
    tick();
    checkOutput("flash_on_2", obs(), exp_v(1'b0, 1'b0, 1'b0, FL_ON));
    tick();
    checkOutput("flash_off_2", obs(), exp_v(1'b0, 1'b0, 1'b0, FL_OFF));
    night = 1'b0;
    tick();
    checkOutput("flash_exit_hg", obs(), exp_v(1'b1, 1'b0, 1'b0, HG_L));
    tick();
    checkOutput("flash_exit_st_drop", obs(), exp_v(1'b0, 1'b0, 1'b0, HG_L));

    // Asynchronous reset in FG with walk lit takes effect without a clock edge
    applyStimulus();
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_mid_fg", obs(), exp_v(1'b1, 1'b0, 1'b0, HG_L));
    @(negedge clk1);
    rst_n = 1'b1;
    cyc   = 0;
    tick();
    checkOutput("post_reset_st_drop", obs(), exp_v(1'b0, 1'b0, 1'b0, HG_L));

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
